cart_bus_bridge: RTL and testbench

Bus bridge sitting directly downstream of the 6502 CPU wrapper on the cartridge. It generates the CPU clock-enable strobe, takes the registered CPU address/data/write-enable, and applies the cartridge memory map and bank switching. It runs each access over a req/ack handshake to external 20-bit memory, holds the CPU off with `cpu_ready` until data returns, and times out hung accesses.

---
 rtl/cart_bus_bridge.sv | 128 ++++++++++++
 tb/tb_cart_bus_bridge.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cart_bus_bridge.sv
// Cartridge bus bridge behind the 6502 wrapper. It generates the CPU clock enable,
// decodes the memory map and bank register, and runs req/ack memory accesses with a timeout.
module cart_bus_bridge #(
  parameter int CLK_DIV = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        enable,
  input  logic [15:0] cpu_ab,
  input  logic [7:0]  cpu_dbo,
  input  logic        cpu_we,
  output logic [7:0]  cpu_dbi,
  output logic        cpu_ready,
  output logic [19:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [5:0]  bank,
  output logic        bus_err
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLK_DIV - 2);
  localparam logic [7:0]       TO_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LATCH  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t           state_reg;
  logic [DIV_W-1:0] div_reg;
  logic [7:0]       to_reg;

  logic [19:0] phys_next;
  logic        bank_wr_next;

  always_comb begin
    phys_next    = 20'h00000;
    bank_wr_next = 1'b0;
    if (!cpu_ab[15]) begin
      phys_next = {5'b00000, cpu_ab[14:0]};
    end else if (!cpu_ab[14]) begin
      phys_next = {bank, cpu_ab[13:0]};
    end else begin
      phys_next    = {6'h3F, cpu_ab[13:0]};
      bank_wr_next = cpu_we;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      div_reg   <= '0;
      to_reg    <= 8'h00;
      enable    <= 1'b0;
      cpu_ready <= 1'b1;
      cpu_dbi   <= 8'h00;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 20'h00000;
      mem_wdata <= 8'h00;
      bank      <= 6'h00;
      bus_err   <= 1'b0;
    end else begin
      enable <= 1'b0;
      case (state_reg)
        IDLE: begin
          // Look one cycle ahead so the strobe lands on the final idle cycle.
          enable <= (div_reg == DIV_PRE);
          if (div_reg == DIV_LAST) begin
            div_reg   <= '0;
            state_reg <= LATCH;
            cpu_ready <= 1'b0;
          end else begin
            div_reg <= div_reg + 1'b1;
          end
        end
        LATCH: begin
          if (bank_wr_next) begin
            bank      <= cpu_dbo[5:0];
            state_reg <= IDLE;
            cpu_ready <= 1'b1;
          end else begin
            mem_addr  <= phys_next;
            mem_wdata <= cpu_dbo;
            mem_we    <= cpu_we;
            mem_req   <= 1'b1;
            to_reg    <= 8'h00;
            state_reg <= ACCESS;
          end
        end
        ACCESS: begin
          // An ack in the final timeout cycle wins over the timeout.
          if (mem_ack) begin
            if (!mem_we) begin
              cpu_dbi <= mem_rdata;
            end
            mem_req   <= 1'b0;
            state_reg <= IDLE;
            cpu_ready <= 1'b1;
          end else if (to_reg == TO_LAST) begin
            bus_err <= 1'b1;
            if (!mem_we) begin
              cpu_dbi <= 8'hFF;
            end
            mem_req   <= 1'b0;
            state_reg <= IDLE;
            cpu_ready <= 1'b1;
          end else begin
            to_reg <= to_reg + 8'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          cpu_ready <= 1'b1;
          mem_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cart_bus_bridge.sv
// Randomized bench for cart_bus_bridge: a memory-map/bank model plus a byte memory
// predicts addresses, read data, error flag and handshake durations.
module tb_cart_bus_bridge;
  localparam int CLK_DIV = 4;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] cpu_ab;
  logic [7:0]  cpu_dbo;
  logic        cpu_we;
  logic [7:0]  cpu_dbi;
  logic        cpu_ready;
  logic [19:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_req;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [5:0]  bank;
  logic        bus_err;

  cart_bus_bridge #(.CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .cpu_ab(cpu_ab), .cpu_dbo(cpu_dbo), .cpu_we(cpu_we),
    .cpu_dbi(cpu_dbi), .cpu_ready(cpu_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .bank(bank), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_txn = 0;

  // Reference state
  logic [7:0] mem_m [int];
  logic [5:0] bank_m = 6'h00;
  logic       err_m  = 1'b0;
  logic [7:0] dbi_m  = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] map_addr(input logic [15:0] ab);
    if (ab < 16'h8000)      return {5'b00000, ab[14:0]};
    else if (ab < 16'hC000) return {bank_m, ab[13:0]};
    else                    return {6'h3F, ab[13:0]};
  endfunction

  // Waits for the next enable (issuing stray acks meanwhile), then runs one CPU cycle.
  // wait_n: ACCESS cycle index (0-based) carrying the ack; >= TIMEOUT means no ack.
  task automatic do_txn(input logic [15:0] ab, input logic [7:0] dbo, input logic we,
                        input int wait_n, input int exp_gap);
    int gap;
    int acc_n;
    int exp_acc;
    logic [19:0] exp_addr;
    logic [7:0]  rd;
    logic        bank_wr;
    cpu_ab   = ab;
    cpu_dbo  = dbo;
    cpu_we   = we;
    bank_wr  = (ab >= 16'hC000) && we;
    exp_addr = map_addr(ab);
    if (!mem_m.exists(int'(exp_addr))) mem_m[int'(exp_addr)] = 8'($urandom);
    rd  = mem_m[int'(exp_addr)];
    gap = 0;
    while (!enable && gap < 4 * CLK_DIV) begin
      mem_ack   = ($urandom_range(0, 3) == 0);
      mem_rdata = 8'($urandom);
      @(negedge clk);
      gap++;
    end
    mem_ack = 1'b0;
    chk("enable_gap", gap, exp_gap);
    @(negedge clk);
    chk("enable_width", enable, 1'b0);
    chk("latch_ready", cpu_ready, 1'b0);
    chk("latch_req", mem_req, 1'b0);
    @(negedge clk);
    if (bank_wr) begin
      bank_m = dbo[5:0];
      chk("bank", bank, bank_m);
      chk("bankwr_req", mem_req, 1'b0);
      chk("bankwr_ready", cpu_ready, 1'b1);
      exp_acc = 0;
    end else begin
      exp_acc = (wait_n < TIMEOUT) ? wait_n + 1 : TIMEOUT;
      acc_n = 0;
      while (mem_req && acc_n < TIMEOUT + 2) begin
        chk("acc_ready", cpu_ready, 1'b0);
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_we", mem_we, we);
        if (we) chk("mem_wdata", mem_wdata, dbo);
        mem_rdata = 8'($urandom);
        if (acc_n == wait_n) begin
          mem_ack   = 1'b1;
          mem_rdata = rd;
        end
        @(negedge clk);
        mem_ack = 1'b0;
        acc_n++;
      end
      chk("req_cycles", acc_n, exp_acc);
      if (wait_n < TIMEOUT) begin
        if (we) mem_m[int'(exp_addr)] = dbo;
        else    dbi_m = rd;
      end else begin
        err_m = 1'b1;
        if (!we) dbi_m = 8'hFF;
      end
      chk("done_ready", cpu_ready, 1'b1);
    end
    chk("cpu_dbi", cpu_dbi, dbi_m);
    chk("bus_err", bus_err, err_m);
    chk("bank_hold", bank, bank_m);
    n_txn++;
    $display("txn %0d ab=%h we=%b dbo=%h wait=%0d addr=%h acc=%0d dbi=%h err=%b bank=%h",
             n_txn, ab, we, dbo, wait_n, exp_addr, exp_acc, dbi_m, err_m, bank_m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] ab;
    logic        we;
    int          w;
    int          g;
    rst = 1'b1; cpu_ab = 16'h0000; cpu_dbo = 8'h00; cpu_we = 1'b0;
    mem_ack = 1'b0; mem_rdata = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_enable", enable, 1'b0);
    chk("rst_ready", cpu_ready, 1'b1);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_dbi", cpu_dbi, 8'h00);
    chk("rst_addr", mem_addr, 20'h0);
    chk("rst_bank", bank, 6'h00);
    chk("rst_err", bus_err, 1'b0);
    rst = 1'b0;

    // Directed: zero-wait read, bank write, banked read, waited read, timeout, recovery.
    mem_m[int'(20'h01234)] = 8'hA5;
    do_txn(16'h1234, 8'h00, 1'b0, 0, CLK_DIV - 1);
    chk("read_1234", cpu_dbi, 8'hA5);
    do_txn(16'hC000, 8'h05, 1'b1, 0, CLK_DIV - 1);
    chk("bank_05", bank, 6'h05);
    do_txn(16'h8010, 8'h00, 1'b0, 0, CLK_DIV - 1);
    do_txn(16'hFFFC, 8'h00, 1'b0, 3, CLK_DIV - 1);
    do_txn(16'h0100, 8'h00, 1'b0, TIMEOUT, CLK_DIV - 1);
    chk("timeout_dbi", cpu_dbi, 8'hFF);
    do_txn(16'h0101, 8'h00, 1'b0, 0, CLK_DIV - 1);
    chk("err_sticky", bus_err, 1'b1);
    do_txn(16'h0102, 8'h3C, 1'b1, TIMEOUT - 1, CLK_DIV - 1);

    // Reset in the middle of an access, then a late ack.
    cpu_ab = 16'h0200; cpu_we = 1'b0;
    g = 0;
    while (!enable && g < 4 * CLK_DIV) begin @(negedge clk); g++; end
    chk("rst_case_gap", g, CLK_DIV - 1);
    repeat (3) @(negedge clk);
    chk("pre_rst_req", mem_req, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    bank_m = 6'h00; err_m = 1'b0; dbi_m = 8'h00;
    chk("midrst_req", mem_req, 1'b0);
    chk("midrst_ready", cpu_ready, 1'b1);
    chk("midrst_bank", bank, 6'h00);
    chk("midrst_err", bus_err, 1'b0);
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h5A;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("late_ack_dbi", cpu_dbi, 8'h00);
    chk("late_ack_req", mem_req, 1'b0);
    chk("late_ack_ready", cpu_ready, 1'b1);
    do_txn(16'h0203, 8'h00, 1'b0, 1, CLK_DIV - 2);

    // Randomized traffic over a small address pool so reads revisit written bytes.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0, 1:    ab = 16'h0040 + 16'($urandom_range(0, 7));
        2:       ab = 16'h8020 + 16'($urandom_range(0, 7));
        default: ab = 16'hC000 + 16'($urandom_range(0, 7));
      endcase
      we = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 9))
        0, 1, 2, 3: w = $urandom_range(0, 3);
        4:          w = TIMEOUT - 1;
        5:          w = TIMEOUT;
        default:    w = $urandom_range(0, 2);
      endcase
      do_txn(ab, 8'($urandom), we, w, CLK_DIV - 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
